// File: rtl/pa_ifu_btb_set.sv
// Fully associative BTB set: ENTRY_NUM entries of {vld, tag, tgt, cnt}.
// Registered lookup port, update port (train on hit / allocate on taken miss),
// and a global clear that drops valid bits but keeps payload.
module pa_ifu_btb_set #(
    parameter int unsigned ENTRY_NUM = 8,
    parameter int unsigned TAG_WIDTH = 16,
    parameter int unsigned TGT_WIDTH = 16,
    parameter int unsigned CNT_WIDTH = 2
) (
    input  logic                 btb_entry_clk,
    input  logic                 cpurst_b,
    input  logic                 btb_clr_all,
    input  logic                 btb_rd_vld,
    input  logic [TAG_WIDTH-1:0] btb_rd_tag,
    input  logic                 btb_upd_vld,
    input  logic [TAG_WIDTH-1:0] btb_upd_tag,
    input  logic [TGT_WIDTH-1:0] btb_upd_tgt,
    input  logic                 btb_upd_taken,
    output logic                 btb_rd_out_vld,
    output logic                 btb_rd_hit,
    output logic [TGT_WIDTH-1:0] btb_rd_tgt,
    output logic                 btb_rd_taken,
    output logic                 btb_full
);

    localparam int unsigned PTR_W = $clog2(ENTRY_NUM);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_WEAK = CNT_WIDTH'(1) << (CNT_WIDTH - 1);

    logic [ENTRY_NUM-1:0] r_vld;
    logic [TAG_WIDTH-1:0] r_tag [ENTRY_NUM];
    logic [TGT_WIDTH-1:0] r_tgt [ENTRY_NUM];
    logic [CNT_WIDTH-1:0] r_cnt [ENTRY_NUM];
    logic [PTR_W-1:0]     r_vic_ptr;

    logic                 r_out_vld;
    logic                 r_out_hit;
    logic [TGT_WIDTH-1:0] r_out_tgt;
    logic                 r_out_taken;

    logic                 w_rd_hit;
    logic [TGT_WIDTH-1:0] w_rd_tgt;
    logic                 w_rd_taken;
    logic                 w_upd_hit;
    logic [PTR_W-1:0]     w_upd_idx;
    logic                 w_inv_found;
    logic [PTR_W-1:0]     w_inv_idx;
    logic [PTR_W-1:0]     w_alloc_idx;

    // Lookup match against current state; lowest matching index wins
    always_comb begin
        w_rd_hit   = 1'b0;
        w_rd_tgt   = '0;
        w_rd_taken = 1'b0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (!w_rd_hit && r_vld[i] && (r_tag[i] == btb_rd_tag)) begin
                w_rd_hit   = 1'b1;
                w_rd_tgt   = r_tgt[i];
                w_rd_taken = r_cnt[i][CNT_WIDTH-1];
            end
        end
    end

    // Update match and lowest-index invalid entry search
    always_comb begin
        w_upd_hit   = 1'b0;
        w_upd_idx   = '0;
        w_inv_found = 1'b0;
        w_inv_idx   = '0;
        for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
            if (!w_upd_hit && r_vld[i] && (r_tag[i] == btb_upd_tag)) begin
                w_upd_hit = 1'b1;
                w_upd_idx = PTR_W'(i);
            end
            if (!w_inv_found && !r_vld[i]) begin
                w_inv_found = 1'b1;
                w_inv_idx   = PTR_W'(i);
            end
        end
    end

    assign w_alloc_idx = w_inv_found ? w_inv_idx : r_vic_ptr;
    assign btb_full    = &r_vld;

    // Entry state: clear beats update; hit trains counter, taken miss allocates
    always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_vld     <= '0;
            r_vic_ptr <= '0;
            for (int unsigned i = 0; i < ENTRY_NUM; i++) begin
                r_tag[i] <= '0;
                r_tgt[i] <= '0;
                r_cnt[i] <= '0;
            end
        end else if (btb_clr_all) begin
            r_vld     <= '0;
            r_vic_ptr <= '0;
        end else if (btb_upd_vld) begin
            if (w_upd_hit) begin
                if (btb_upd_taken) begin
                    r_tgt[w_upd_idx] <= btb_upd_tgt;
                    if (r_cnt[w_upd_idx] != CNT_MAX)
                        r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + 1'b1;
                end else if (r_cnt[w_upd_idx] != '0) begin
                    r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - 1'b1;
                end
            end else if (btb_upd_taken) begin
                r_vld[w_alloc_idx] <= 1'b1;
                r_tag[w_alloc_idx] <= btb_upd_tag;
                r_tgt[w_alloc_idx] <= btb_upd_tgt;
                r_cnt[w_alloc_idx] <= CNT_WEAK;
                if (!w_inv_found)
                    r_vic_ptr <= r_vic_ptr + 1'b1;
            end
        end
    end

    // Registered lookup result; payload holds when no lookup is issued
    always_ff @(posedge btb_entry_clk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_out_vld   <= 1'b0;
            r_out_hit   <= 1'b0;
            r_out_tgt   <= '0;
            r_out_taken <= 1'b0;
        end else begin
            r_out_vld <= btb_rd_vld;
            if (btb_rd_vld) begin
                r_out_hit   <= w_rd_hit;
                r_out_tgt   <= w_rd_tgt;
                r_out_taken <= w_rd_taken;
            end
        end
    end

    assign btb_rd_out_vld = r_out_vld;
    assign btb_rd_hit     = r_out_hit;
    assign btb_rd_tgt     = r_out_tgt;
    assign btb_rd_taken   = r_out_taken;

endmodule
